// File: rtl/nf10_axis_pkt_loopback.sv
// nf10_axis_pkt_loopback
// Store-and-forward AXI4-Stream packet buffer for the traffic gen/check
// loopback path. Whole packets are written speculatively into a RAM, made
// visible to the reader only when tlast commits them, and replayed unchanged
// through a two-entry prefetch/skid stage. Packets that do not fit are
// dropped whole; the generator is never back-pressured.

module nf10_axis_pkt_loopback #(
    parameter int C_AXIS_DATA_WIDTH  = 64,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_ADDR_WIDTH       = 9
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    // ingress from the generator
    input  logic [C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tlast,
    output logic                             s_axis_tready,
    // egress to the checker
    output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    // status counters
    output logic [31:0]                      pkt_in_cnt,
    output logic [31:0]                      pkt_out_cnt,
    output logic [31:0]                      pkt_drop_cnt
);

    localparam int DW     = C_AXIS_DATA_WIDTH;
    localparam int SW     = C_AXIS_DATA_WIDTH / 8;
    localparam int UW     = C_AXIS_TUSER_WIDTH;
    localparam int WORD_W = 1 + UW + SW + DW;
    localparam int DEPTH  = 1 << C_ADDR_WIDTH;
    localparam int PTR_W  = C_ADDR_WIDTH + 1;

    localparam logic [PTR_W-1:0] FULL_GAP = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    // wr_ptr runs ahead speculatively; wr_commit marks the end of the last
    // whole packet; rd_ptr counts words released from RAM into the output stage.
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   wr_commit;
    logic [PTR_W-1:0]   rd_ptr;

    logic               beat;
    logic               full;
    logic               wr_en;
    logic               rewind;
    logic               commit;
    logic               drop_inc;
    logic [WORD_W-1:0]  wr_word_p0;

    logic [WORD_W-1:0]  mem [0:DEPTH-1];

    logic               rd_en;
    logic               vld_p1;
    logic [WORD_W-1:0]  ram_q_p1;

    logic [1:0]         stg_cnt;
    logic [1:0]         stg_cnt_nxt;
    logic               pop;
    logic               load_head;
    logic               head_from_skid;
    logic               load_skid;
    logic [WORD_W-1:0]  out_p2;
    logic [WORD_W-1:0]  skid_p2;

    // ---- stage p0: ingress beat, full test, FSM decisions ----
    assign beat       = s_axis_tvalid && s_axis_tready;
    assign full       = (wr_ptr - rd_ptr) == FULL_GAP;
    assign wr_word_p0 = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};

    // Ingress FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ingress FSM next state: write, commit, rewind or drop the current beat.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        rewind    = 1'b0;
        commit    = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (beat) begin
                    if (!full) begin
                        wr_en = 1'b1;
                        if (s_axis_tlast) begin
                            commit = 1'b1;
                        end else begin
                            state_nxt = WRITE;
                        end
                    end else if (s_axis_tlast) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end
            WRITE: begin
                if (beat) begin
                    if (!full) begin
                        wr_en = 1'b1;
                        if (s_axis_tlast) begin
                            commit    = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        // Packet cannot fit: discard what was written of it.
                        rewind = 1'b1;
                        if (s_axis_tlast) begin
                            drop_inc  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DROP;
                        end
                    end
                end
            end
            DROP: begin
                if (beat && s_axis_tlast) begin
                    drop_inc  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ingress ready, write pointers and ingress-side counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axis_tready <= 1'b0;
            wr_ptr        <= '0;
            wr_commit     <= '0;
            pkt_in_cnt    <= '0;
            pkt_drop_cnt  <= '0;
        end else begin
            s_axis_tready <= 1'b1;
            if (rewind) begin
                wr_ptr <= wr_commit;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (commit) begin
                wr_commit  <= wr_ptr + PTR_ONE;
                pkt_in_cnt <= pkt_in_cnt + 32'd1;
            end
            if (drop_inc) begin
                pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
            end
        end
    end

    // ---- stage p1: synchronous RAM read of committed words ----
    // Packet RAM: write at the speculative pointer, read below the commit mark.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[C_ADDR_WIDTH-1:0]] <= wr_word_p0;
        end
        if (rd_en) begin
            ram_q_p1 <= mem[rd_ptr[C_ADDR_WIDTH-1:0]];
        end
    end

    // Read pointer and read-data valid flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // ---- stage p2: two-entry prefetch/skid output stage ----
    // A read is only issued when its word is guaranteed a free entry next
    // cycle, so the stage never overflows even if the checker stalls.
    always_comb begin
        pop            = (stg_cnt != 2'd0) && m_axis_tready;
        stg_cnt_nxt    = stg_cnt + {1'b0, vld_p1} - {1'b0, pop};
        rd_en          = (rd_ptr != wr_commit) && (stg_cnt_nxt < 2'd2);
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (stg_cnt)
            2'd0: begin
                load_head = vld_p1;
            end
            2'd1: begin
                load_head = vld_p1 && pop;
                load_skid = vld_p1 && !pop;
            end
            default: begin
                load_head      = pop;
                head_from_skid = 1'b1;
                load_skid      = vld_p1 && pop;
            end
        endcase
    end

    // Head entry, occupancy and sent-packet counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stg_cnt     <= 2'd0;
            out_p2      <= '0;
            pkt_out_cnt <= '0;
        end else begin
            stg_cnt <= stg_cnt_nxt;
            if (load_head) begin
                out_p2 <= head_from_skid ? skid_p2 : ram_q_p1;
            end
            if (pop && out_p2[WORD_W-1]) begin
                pkt_out_cnt <= pkt_out_cnt + 32'd1;
            end
        end
    end

    // Skid entry holds the word behind the head while the checker stalls.
    always_ff @(posedge aclk) begin
        if (load_skid) begin
            skid_p2 <= ram_q_p1;
        end
    end

    assign m_axis_tvalid = (stg_cnt != 2'd0);
    assign m_axis_tdata  = out_p2[DW-1:0];
    assign m_axis_tstrb  = out_p2[DW+SW-1:DW];
    assign m_axis_tuser  = out_p2[DW+SW+UW-1:DW+SW];
    assign m_axis_tlast  = out_p2[WORD_W-1];

endmodule
